// File: rtl/ctrl_pkg.sv
// Shared encodings for the handshaked multicycle control FSM:
// opcodes, state codes, trap causes and datapath select fields.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMCOMP   = 4'd2,
        S_MEMRD     = 4'd3,
        S_WRITEBACK = 4'd4,
        S_MEMWR     = 4'd5,
        S_EXEC      = 4'd6,
        S_RCOMP     = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IEXEC_SE  = 4'd10,
        S_IEXEC_ZE  = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        TC_NONE    = 2'b00,
        TC_ILLEGAL = 2'b01,
        TC_TIMEOUT = 2'b10
    } trap_cause_t;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_TRAP   = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;
    localparam logic [1:0] ALU_IMM  = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [5:0] OP_NOOP = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000001;
    localparam logic [5:0] OP_BNE  = 6'b100001;
    localparam logic [5:0] OP_BLT  = 6'b100010;
    localparam logic [5:0] OP_BLE  = 6'b100011;
    localparam logic [5:0] OP_ADDI = 6'b110010;
    localparam logic [5:0] OP_SUBI = 6'b110011;
    localparam logic [5:0] OP_LI   = 6'b111001;
    localparam logic [5:0] OP_LWI  = 6'b111011;
    localparam logic [5:0] OP_LW   = 6'b111101;
    localparam logic [5:0] OP_SWI  = 6'b111100;

    typedef enum logic [3:0] {
        OC_NOOP,
        OC_J,
        OC_R,
        OC_BR,
        OC_ISE,
        OC_IZE,
        OC_LI,
        OC_LD,
        OC_ST,
        OC_ILL
    } op_class_t;

    typedef struct packed {
        logic       zero_or_sign;
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       trap;
        logic       instr_done;
    } ctrl_t;

    // R-type spans 010000-010111, ORI..SLTI spans 110100-110111
    function automatic op_class_t op_class(input logic [5:0] op);
        op_class_t c;
        c = OC_ILL;
        unique case (1'b1)
            op == OP_NOOP:               c = OC_NOOP;
            op == OP_J:                  c = OC_J;
            op[5:3] == 3'b010:           c = OC_R;
            op inside {OP_BNE, OP_BLT,
                       OP_BLE}:          c = OC_BR;
            op inside {OP_ADDI,
                       OP_SUBI}:         c = OC_ISE;
            op[5:2] == 4'b1101:          c = OC_IZE;
            op == OP_LI:                 c = OC_LI;
            op inside {OP_LWI, OP_LW}:   c = OC_LD;
            op == OP_SWI:                c = OC_ST;
            default:                     c = OC_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_controller_hs_if.sv
// Controller-side bundle: opcode and memory handshake in,
// datapath control strobes and debug state out.
interface mc_controller_hs_if #(
    parameter int OPCODE_W = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                hold;
    logic                zero_or_sign;
    logic                pc_write_cond;
    logic                pc_write;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                ir_write;
    logic [1:0]          pc_source;
    logic [1:0]          alu_op;
    logic [1:0]          alu_src_b;
    logic                alu_src_a;
    logic                reg_write;
    logic                reg_dst;
    logic                trap;
    logic [1:0]          trap_cause;
    logic                instr_done;
    logic [3:0]          state_dbg;

    modport master (
        input  opcode, mem_ready, hold,
        output zero_or_sign, pc_write_cond, pc_write,
        output i_or_d, mem_read, mem_write, mem_to_reg,
        output ir_write, pc_source, alu_op, alu_src_b,
        output alu_src_a, reg_write, reg_dst, trap,
        output trap_cause, instr_done, state_dbg
    );

    modport slave (
        output opcode, mem_ready, hold,
        input  zero_or_sign, pc_write_cond, pc_write,
        input  i_or_d, mem_read, mem_write, mem_to_reg,
        input  ir_write, pc_source, alu_op, alu_src_b,
        input  alu_src_a, reg_write, reg_dst, trap,
        input  trap_cause, instr_done, state_dbg
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits for ready and flags
// the cycle on which the wait limit is reached without ready.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic timeout
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !ready) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // ready on the limit cycle completes normally
    assign timeout = enable && !ready && (cnt == LIMIT);

endmodule

// File: rtl/mc_controller_hs.sv
// Multicycle CPU control FSM with memory ready handshake,
// bus timeout, illegal-opcode trap and fetch hold.
module mc_controller_hs
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5,
    parameter bit TRAP_EN     = 1'b1
) (
    input logic               clk,
    input logic               reset_n,
    mc_controller_hs_if.master bus
);
    state_t      state;
    state_t      next_state;
    state_t      fault_dest;
    trap_cause_t cause_q;
    op_class_t   oc;
    ctrl_t       c;
    ctrl_t       g;
    logic [5:0]  op6;
    logic        parked;
    logic        waiting;
    logic        t_clear;
    logic        timeout;

    // upper opcode bits beyond the 6-bit encodings must be zero
    assign op6 = 6'(bus.opcode);
    assign oc  = (bus.opcode == OPCODE_W'(op6))
               ? op_class(op6) : OC_ILL;

    assign fault_dest = TRAP_EN ? S_TRAP : S_FETCH;

    assign parked  = (state == S_FETCH) && bus.hold;
    assign waiting = ((state == S_FETCH) && !bus.hold)
                  || (state == S_MEMRD)
                  || (state == S_MEMWR);
    assign t_clear = (next_state != state) || timeout || parked;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (t_clear),
        .enable  (waiting),
        .ready   (bus.mem_ready),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_q <= TC_NONE;
        end else if (next_state == S_TRAP) begin
            cause_q <= (state == S_DECODE)
                     ? TC_ILLEGAL : TC_TIMEOUT;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_FETCH: begin
                if (bus.hold) begin
                    next_state = S_FETCH;
                end else if (bus.mem_ready) begin
                    next_state = S_DECODE;
                end else if (timeout) begin
                    next_state = fault_dest;
                end
            end
            S_DECODE: begin
                unique case (oc)
                    OC_NOOP: next_state = S_FETCH;
                    OC_J:    next_state = S_JUMP;
                    OC_R:    next_state = S_EXEC;
                    OC_BR:   next_state = S_BRANCH;
                    OC_ISE:  next_state = S_IEXEC_SE;
                    OC_IZE:  next_state = S_IEXEC_ZE;
                    OC_LI,
                    OC_LD,
                    OC_ST:   next_state = S_MEMCOMP;
                    default: next_state = fault_dest;
                endcase
            end
            S_MEMCOMP: begin
                unique case (oc)
                    OC_LI:   next_state = S_RCOMP;
                    OC_LD:   next_state = S_MEMRD;
                    OC_ST:   next_state = S_MEMWR;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    next_state = S_WRITEBACK;
                end else if (timeout) begin
                    next_state = fault_dest;
                end
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    next_state = S_FETCH;
                end else if (timeout) begin
                    next_state = fault_dest;
                end
            end
            S_EXEC,
            S_IEXEC_SE,
            S_IEXEC_ZE: next_state = S_RCOMP;
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        c = '0;
        unique case (state)
            S_FETCH: begin
                c.mem_read  = !bus.hold;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = bus.mem_ready && !bus.hold;
                c.ir_write  = bus.mem_ready && !bus.hold;
            end
            S_DECODE: begin
                c.alu_src_b  = SRCB_BOFF;
                c.instr_done = (oc == OC_NOOP);
            end
            S_MEMCOMP: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.i_or_d   = 1'b1;
                c.mem_read = 1'b1;
            end
            S_WRITEBACK: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c.i_or_d     = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = bus.mem_ready;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNC;
            end
            S_RCOMP: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCS_BRANCH;
                c.instr_done    = 1'b1;
            end
            S_JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PCS_JUMP;
                c.instr_done = 1'b1;
            end
            S_IEXEC_SE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_IMM;
            end
            S_IEXEC_ZE: begin
                c.alu_src_a    = 1'b1;
                c.alu_src_b    = SRCB_IMM;
                c.alu_op       = ALU_IMM;
                c.zero_or_sign = 1'b1;
            end
            S_TRAP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_TRAP;
                c.trap      = 1'b1;
            end
            default: c = '0;
        endcase
    end

    // every strobe is held low for as long as reset is asserted
    assign g = reset_n ? c : '0;

    assign bus.zero_or_sign  = g.zero_or_sign;
    assign bus.pc_write_cond = g.pc_write_cond;
    assign bus.pc_write      = g.pc_write;
    assign bus.i_or_d        = g.i_or_d;
    assign bus.mem_read      = g.mem_read;
    assign bus.mem_write     = g.mem_write;
    assign bus.mem_to_reg    = g.mem_to_reg;
    assign bus.ir_write      = g.ir_write;
    assign bus.pc_source     = g.pc_source;
    assign bus.alu_op        = g.alu_op;
    assign bus.alu_src_b     = g.alu_src_b;
    assign bus.alu_src_a     = g.alu_src_a;
    assign bus.reg_write     = g.reg_write;
    assign bus.reg_dst       = g.reg_dst;
    assign bus.trap          = g.trap;
    assign bus.instr_done    = g.instr_done;
    assign bus.trap_cause    = reset_n ? cause_q : TC_NONE;
    assign bus.state_dbg     = reset_n ? state : S_FETCH;

endmodule

// File: tb/tb_mc_controller_hs.sv
// Bench for mc_controller_hs: directed vector table, corner
// sequences and random instruction streams vs a reference.
module tb_mc_controller_hs;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] cause;
        logic       zos;
        logic       pcwc;
        logic       pcw;
        logic       iod;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       irw;
        logic [1:0] pcs;
        logic [1:0] aop;
        logic [1:0] asb;
        logic       asa;
        logic       rw;
        logic       rdst;
        logic       trap;
        logic       done;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic       hd;
        logic [3:0] st;
        logic [1:0] cause;
    } vec_t;

    localparam int C_NOOP = 0, C_J = 1, C_R = 2, C_BR = 3;
    localparam int C_ISE = 4, C_IZE = 5, C_LI = 6, C_LD = 7;
    localparam int C_ST = 8, C_ILL = 9;

    localparam logic [5:0] T_NOOP = 6'h00, T_J = 6'h01;
    localparam logic [5:0] T_ADD = 6'h12, T_BLE = 6'h23;
    localparam logic [5:0] T_ADDI = 6'h32, T_ORI = 6'h34;
    localparam logic [5:0] T_LI = 6'h39, T_LWI = 6'h3b;
    localparam logic [5:0] T_LW = 6'h3d, T_SWI = 6'h3c;
    localparam logic [5:0] T_BAD = 6'h2a;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       hold;

    int   n_tests;
    int   n_fail;
    int   seen_done;
    int   retired;
    logic [1:0] exp_cause;
    vec_t tbl[$];
    obs_t o0, o1;

    logic [5:0] legal [23] = '{
        6'h00, 6'h01, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15,
        6'h16, 6'h17, 6'h21, 6'h22, 6'h23, 6'h32, 6'h33, 6'h34,
        6'h35, 6'h36, 6'h37, 6'h39, 6'h3b, 6'h3d, 6'h3c
    };

    mc_controller_hs_if #(.OPCODE_W(6)) b0 ();
    mc_controller_hs_if #(.OPCODE_W(6)) b1 ();

    assign b0.opcode    = opcode;
    assign b0.mem_ready = mem_ready;
    assign b0.hold      = hold;
    assign b1.opcode    = opcode;
    assign b1.mem_ready = mem_ready;
    assign b1.hold      = hold;

    mc_controller_hs #(
        .OPCODE_W(6), .MEM_TIMEOUT(16), .CNT_W(5), .TRAP_EN(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(b0.master)
    );

    mc_controller_hs #(
        .OPCODE_W(6), .MEM_TIMEOUT(16), .CNT_W(5), .TRAP_EN(1'b0)
    ) dut_nt (
        .clk(clk), .reset_n(reset_n), .bus(b1.master)
    );

    assign o0 = {b0.state_dbg, b0.trap_cause, b0.zero_or_sign,
                 b0.pc_write_cond, b0.pc_write, b0.i_or_d,
                 b0.mem_read, b0.mem_write, b0.mem_to_reg,
                 b0.ir_write, b0.pc_source, b0.alu_op,
                 b0.alu_src_b, b0.alu_src_a, b0.reg_write,
                 b0.reg_dst, b0.trap, b0.instr_done};
    assign o1 = {b1.state_dbg, b1.trap_cause, b1.zero_or_sign,
                 b1.pc_write_cond, b1.pc_write, b1.i_or_d,
                 b1.mem_read, b1.mem_write, b1.mem_to_reg,
                 b1.ir_write, b1.pc_source, b1.alu_op,
                 b1.alu_src_b, b1.alu_src_a, b1.reg_write,
                 b1.reg_dst, b1.trap, b1.instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int cls(input logic [5:0] op);
        if (op == 6'h00) return C_NOOP;
        if (op == 6'h01) return C_J;
        if (op inside {[6'h10:6'h17]}) return C_R;
        if (op inside {6'h21, 6'h22, 6'h23}) return C_BR;
        if (op inside {6'h32, 6'h33}) return C_ISE;
        if (op inside {[6'h34:6'h37]}) return C_IZE;
        if (op == 6'h39) return C_LI;
        if (op inside {6'h3b, 6'h3d}) return C_LD;
        if (op == 6'h3c) return C_ST;
        return C_ILL;
    endfunction

    // control word each state must show, from the state table
    function automatic obs_t spec_ctrl(
        input logic [3:0] st, input logic rdy, input logic hd,
        input logic [5:0] op, input logic [1:0] cause);
        obs_t o;
        o = '0;
        o.st = st;
        o.cause = cause;
        case (st)
            4'd0: begin
                o.mr = !hd; o.asb = 2'b01;
                o.pcw = rdy && !hd; o.irw = rdy && !hd;
            end
            4'd1: begin o.asb = 2'b11; o.done = (op == 6'h00); end
            4'd2: begin o.asa = 1; o.asb = 2'b10; end
            4'd3: begin o.iod = 1; o.mr = 1; end
            4'd4: begin o.m2r = 1; o.rw = 1; o.done = 1; end
            4'd5: begin o.iod = 1; o.mw = 1; o.done = rdy; end
            4'd6: begin o.asa = 1; o.aop = 2'b10; end
            4'd7: begin o.rw = 1; o.rdst = 1; o.done = 1; end
            4'd8: begin
                o.asa = 1; o.aop = 2'b01; o.pcwc = 1;
                o.pcs = 2'b01; o.done = 1;
            end
            4'd9: begin o.pcw = 1; o.pcs = 2'b10; o.done = 1; end
            4'd10: begin o.asa = 1; o.asb = 2'b10; o.aop = 2'b11; end
            4'd11: begin
                o.asa = 1; o.asb = 2'b10; o.aop = 2'b11; o.zos = 1;
            end
            4'd12: begin o.pcw = 1; o.pcs = 2'b11; o.trap = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic check(input obs_t got, input obs_t want,
                         input string tag);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got st=%0d ctl=%h want st=%0d ctl=%h",
                     tag, got.st, got, want.st, want);
        end
    endtask

    task automatic cyc(input logic [5:0] op, input logic rdy,
                       input logic hd, input logic [3:0] st,
                       input logic [1:0] cause, input int which,
                       input string tag);
        obs_t got;
        @(negedge clk);
        opcode = op;
        mem_ready = rdy;
        hold = hd;
        #1;
        got = (which == 0) ? o0 : o1;
        check(got, spec_ctrl(st, rdy, hd, op, cause), tag);
        if (which == 0 && got.done === 1'b1) seen_done++;
    endtask

    function automatic void add(input logic [5:0] op, input logic rdy,
                                input logic hd, input logic [3:0] st,
                                input logic [1:0] cause);
        vec_t v;
        v.op = op; v.rdy = rdy; v.hd = hd; v.st = st; v.cause = cause;
        tbl.push_back(v);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 16;
        if (r == 1) return 15;
        return $urandom_range(0, 3);
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] op;
        if ($urandom_range(0, 7) == 0) begin
            for (int k = 0; k < 64; k++) begin
                op = 6'($urandom);
                if (cls(op) == C_ILL) return op;
            end
            return T_BAD;
        end
        return legal[$urandom_range(0, 22)];
    endfunction

    // one instruction: hold, fetch wait, then the class's path
    task automatic run_instr();
        logic [5:0] op;
        logic [3:0] mst;
        int c, w, h;
        op = pick_op();
        c = cls(op);
        h = $urandom_range(0, 2);
        for (int i = 0; i < h; i++)
            cyc(op, rb(), 1'b1, 4'd0, exp_cause, 0, "rnd_hold");
        w = pick_wait();
        for (int i = 0; i < w && i < 16; i++)
            cyc(op, 1'b0, 1'b0, 4'd0, exp_cause, 0, "rnd_fwait");
        if (w >= 16) begin
            exp_cause = 2'b10;
            cyc(op, rb(), rb(), 4'd12, exp_cause, 0, "rnd_ftrap");
            return;
        end
        cyc(op, 1'b1, 1'b0, 4'd0, exp_cause, 0, "rnd_fetch");
        cyc(op, rb(), rb(), 4'd1, exp_cause, 0, "rnd_decode");
        case (c)
            C_NOOP: retired++;
            C_J: begin
                cyc(op, rb(), rb(), 4'd9, exp_cause, 0, "rnd_j");
                retired++;
            end
            C_BR: begin
                cyc(op, rb(), rb(), 4'd8, exp_cause, 0, "rnd_br");
                retired++;
            end
            C_R, C_ISE, C_IZE, C_LI: begin
                mst = (c == C_R) ? 4'd6 : (c == C_ISE) ? 4'd10 :
                      (c == C_IZE) ? 4'd11 : 4'd2;
                cyc(op, rb(), rb(), mst, exp_cause, 0, "rnd_ex");
                cyc(op, rb(), rb(), 4'd7, exp_cause, 0, "rnd_rc");
                retired++;
            end
            C_LD, C_ST: begin
                cyc(op, rb(), rb(), 4'd2, exp_cause, 0, "rnd_mc");
                mst = (c == C_LD) ? 4'd3 : 4'd5;
                w = pick_wait();
                for (int i = 0; i < w && i < 16; i++)
                    cyc(op, 1'b0, 1'b0, mst, exp_cause, 0, "rnd_mwait");
                if (w >= 16) begin
                    exp_cause = 2'b10;
                    cyc(op, rb(), rb(), 4'd12, exp_cause, 0, "rnd_mtrap");
                end else begin
                    cyc(op, 1'b1, 1'b0, mst, exp_cause, 0, "rnd_mdone");
                    if (c == C_LD)
                        cyc(op, rb(), rb(), 4'd4, exp_cause, 0, "rnd_wb");
                    retired++;
                end
            end
            default: begin
                exp_cause = 2'b01;
                cyc(op, rb(), rb(), 4'd12, exp_cause, 0, "rnd_ill");
            end
        endcase
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        seen_done = 0;
        retired = 0;
        reset_n = 1'b0;
        opcode = 6'h00;
        mem_ready = 1'b0;
        hold = 1'b0;

        add(T_ADD, 1, 0, 0, 0); add(T_ADD, 1, 0, 1, 0);
        add(T_ADD, 1, 0, 6, 0); add(T_ADD, 1, 0, 7, 0);
        add(T_LW, 1, 0, 0, 0); add(T_LW, 1, 0, 1, 0);
        add(T_LW, 0, 0, 2, 0); add(T_LW, 0, 0, 3, 0);
        add(T_LW, 0, 0, 3, 0); add(T_LW, 0, 0, 3, 0);
        add(T_LW, 1, 0, 3, 0); add(T_LW, 0, 0, 4, 0);
        add(T_LI, 1, 1, 0, 0); add(T_LI, 0, 1, 0, 0);
        add(T_LI, 1, 1, 0, 0); add(T_LI, 0, 1, 0, 0);
        add(T_LI, 1, 1, 0, 0); add(T_LI, 1, 0, 0, 0);
        add(T_LI, 0, 0, 1, 0); add(T_LI, 0, 1, 2, 0);
        add(T_LI, 0, 0, 7, 0);
        add(T_NOOP, 1, 0, 0, 0); add(T_NOOP, 0, 0, 1, 0);
        add(T_BLE, 1, 0, 0, 0); add(T_BLE, 0, 0, 1, 0);
        add(T_BLE, 0, 0, 8, 0);
        add(T_J, 1, 0, 0, 0); add(T_J, 0, 0, 1, 0);
        add(T_J, 0, 0, 9, 0);
        add(T_ORI, 1, 0, 0, 0); add(T_ORI, 0, 0, 1, 0);
        add(T_ORI, 0, 0, 11, 0); add(T_ORI, 0, 0, 7, 0);
        add(T_ADDI, 1, 0, 0, 0); add(T_ADDI, 0, 0, 1, 0);
        add(T_ADDI, 0, 0, 10, 0); add(T_ADDI, 0, 0, 7, 0);
        add(T_LWI, 1, 0, 0, 0); add(T_LWI, 0, 0, 1, 0);
        add(T_LWI, 0, 0, 2, 0); add(T_LWI, 1, 0, 3, 0);
        add(T_LWI, 0, 0, 4, 0);
        add(T_SWI, 1, 0, 0, 0); add(T_SWI, 0, 0, 1, 0);
        add(T_SWI, 0, 0, 2, 0); add(T_SWI, 0, 0, 5, 0);
        add(T_SWI, 1, 0, 5, 0);
        add(T_BAD, 1, 0, 0, 0); add(T_BAD, 0, 0, 1, 0);
        add(T_BAD, 0, 0, 12, 1); add(T_BAD, 0, 1, 0, 1);

        #3;
        check(o0, '0, "reset_outputs");
        check(o1, '0, "reset_outputs_nt");
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i])
            cyc(tbl[i].op, tbl[i].rdy, tbl[i].hd, tbl[i].st,
                tbl[i].cause, 0, $sformatf("vec%0d", i));

        cyc(T_SWI, 1, 0, 0, 1, 0, "swi_to_fetch");
        cyc(T_SWI, 0, 0, 1, 1, 0, "swi_decode");
        cyc(T_SWI, 0, 0, 2, 1, 0, "swi_memcomp");
        for (int i = 0; i < 16; i++)
            cyc(T_SWI, 0, 0, 5, 1, 0, $sformatf("swi_wait%0d", i));
        cyc(T_SWI, 0, 0, 12, 2, 0, "swi_timeout_trap");
        cyc(T_SWI, 0, 1, 0, 2, 0, "swi_after_trap");

        cyc(T_BAD, 1, 0, 0, 0, 1, "nt_fetch");
        cyc(T_BAD, 0, 0, 1, 0, 1, "nt_decode");
        cyc(T_BAD, 0, 1, 0, 0, 1, "nt_no_trap");
        cyc(T_BAD, 0, 1, 0, 0, 1, "nt_idle");

        cyc(T_ADD, 1, 0, 0, 1, 0, "rst_fetch");
        cyc(T_ADD, 0, 0, 1, 1, 0, "rst_decode");
        cyc(T_ADD, 0, 0, 6, 1, 0, "rst_exec");
        #1;
        reset_n = 1'b0;
        #1;
        check(o0, '0, "async_reset_outputs");
        check(o1, '0, "async_reset_outputs_nt");
        @(negedge clk);
        reset_n = 1'b1;
        cyc(T_ADD, 0, 0, 0, 0, 0, "after_reset_fetch");

        exp_cause = 2'b00;
        seen_done = 0;
        retired = 0;
        for (int n = 0; n < 200; n++) run_instr();
        n_tests++;
        if (seen_done != retired) begin
            n_fail++;
            $display("FAIL rnd_retired: got %0d want %0d",
                     seen_done, retired);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
